// File: rtl/signed_minmax_tracker.sv
// signed_minmax_tracker
// Tracks the signed minimum and maximum of a framed sample stream, along with
// the index of each and the frame length, then presents one result per frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   input handshake; a beat is s_valid && s_ready
//   s_data, s_last    signed sample and end-of-frame marker
//   m_valid/m_ready   result handshake
//   m_min, m_max      frame minimum / maximum (signed)
//   m_min_idx/_max_idx  0-based index of the reported min / max
//   m_count, m_sat    saturating sample count, set when the frame overflowed it
module signed_minmax_tracker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_min,
    output logic [DATA_W-1:0] m_max,
    output logic [CNT_W-1:0]  m_min_idx,
    output logic [CNT_W-1:0]  m_max_idx,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_sat
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0]  min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    // Keeps s_ready low until the first clock edge after reset releases.
    logic              run_q;
    logic              beat;

    assign s_ready = run_q && (state_q != StHold);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        unique case (state_q)
            StIdle: begin
                if (beat) begin
                    min_d     = s_data;
                    max_d     = s_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    sat_d     = 1'b0;
                    state_d   = s_last ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (beat) begin
                    // Strict less-than keeps the earliest min; <= takes the latest max.
                    // The current count is this sample's index (pinned once saturated).
                    if ($signed(s_data) < $signed(min_q)) begin
                        min_d     = s_data;
                        min_idx_d = cnt_q;
                    end
                    if ($signed(max_q) <= $signed(s_data)) begin
                        max_d     = s_data;
                        max_idx_d = cnt_q;
                    end
                    if (cnt_q == CntMax) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = s_last ? StHold : StAccum;
                end
            end
            StHold: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            run_q     <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign m_valid   = (state_q == StHold);
    assign m_min     = min_q;
    assign m_max     = max_q;
    assign m_min_idx = min_idx_q;
    assign m_max_idx = max_idx_q;
    assign m_count   = cnt_q;
    assign m_sat     = sat_q;

endmodule

// File: doc/signed_minmax_tracker.md
SIGNED_MINMAX_TRACKER -- requirements
Module: signed_minmax_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width (two's-complement signed).
REQ-002 SHALL have parameter CNT_W, default 16, width of the sample count and index fields.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1  an input sample is offered.
REQ-006 SHALL have port s_ready  output  1  the block accepts the sample this cycle.
REQ-007 SHALL have port s_data  input  DATA_W  signed sample.
REQ-008 SHALL have port s_last  input  1  the sample is the final one of its frame.
REQ-009 SHALL have port m_valid  output  1  a frame result is presented.
REQ-010 SHALL have port m_ready  input  1  the downstream stage takes the result.
REQ-011 SHALL have port m_min / m_max  output  DATA_W each  frame minimum / maximum (signed).
REQ-012 SHALL have port m_min_idx / m_max_idx  output  CNT_W each  index (0-based) of the reported min / max.
REQ-013 SHALL have port m_count  output  CNT_W  number of samples in the frame, saturating.
REQ-014 SHALL have port m_sat  output  1  the frame length exceeded 2^CNT_W-1.

Function
REQ-015 SHALL accept a sample only on a cycle where s_valid and s_ready are both 1 (the "beat").
REQ-016 SHALL implement states IDLE (no sample in the current frame), ACCUM (at least one sample taken) and HOLD (result presented).
REQ-017 SHALL drive s_ready=1 in IDLE and ACCUM, and s_ready=0 in HOLD.
REQ-018 SHALL, on a beat in IDLE, load min=max=s_data, min_idx=max_idx=0, count=1 and sat=0.
REQ-019 SHALL, on a beat in ACCUM, replace min (and min_idx) only when s_data < min under signed comparison, so a tie keeps the earliest index.
REQ-020 SHALL, on a beat in ACCUM, replace max (and max_idx) when max <= s_data under signed comparison, so a tie takes the latest index.
REQ-021 SHALL use the index of a sample equal to the count value before that beat.
REQ-022 SHALL saturate count at 2^CNT_W-1, set sat, and thereafter record index 2^CNT_W-1 for any later min/max update.
REQ-023 SHALL move to HOLD on a beat with s_last=1, from either IDLE or ACCUM, after applying that sample; a single-sample frame is legal.
REQ-024 SHALL otherwise move from IDLE to ACCUM on a beat, and stay in ACCUM on a beat with s_last=0.
REQ-025 SHALL assert m_valid during HOLD only, starting the cycle after the s_last beat (latency 1).
REQ-026 SHALL hold all m_* outputs stable while m_valid=1 and m_ready=0.
REQ-027 SHALL return to IDLE on the cycle after m_valid and m_ready are both 1; s_ready rises in that same next cycle.
REQ-028 SHALL ignore s_data and s_last when no beat occurs.
REQ-029 SHALL treat m_ready as don't-care outside HOLD.
REQ-030 SHALL compare across the full signed range, so the most negative value (0x80000000 at DATA_W=32) is the smallest and 0x7FFFFFFF is the largest.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, s_ready=0, m_valid=0, all m_* data outputs to 0, and m_sat=0.
REQ-032 SHALL drive s_ready=1 from the first clock edge after rst_n deasserts.
REQ-033 SHALL, on reset asserted mid-frame or during HOLD, discard the partial frame or pending result, with no output produced for it.

Verification
REQ-034 SHALL be checked with frame {5, -3, 7, -3, 7} with s_last on the 5th beat -> m_min=-3, m_min_idx=1, m_max=7, m_max_idx=4, m_count=5, m_sat=0, with m_valid in the cycle after the last beat.
REQ-035 SHALL be checked with a single-sample frame {0x80000000} with s_last -> m_min=m_max=0x80000000, both indices 0, m_count=1.
REQ-036 SHALL be checked with frame {0x7FFFFFFF, 0x80000000, -1}, then m_ready held 0 for 4 cycles -> m_min=0x80000000 at idx 1, m_max=0x7FFFFFFF at idx 0, outputs stable throughout, s_ready=0 until the cycle after the handshake.
REQ-037 SHALL be checked at CNT_W=4 with 20 ascending samples 0..19 -> m_count=15, m_sat=1, m_max=19, m_max_idx=15, m_min=0, m_min_idx=0.
REQ-038 SHALL be checked by pulsing rst_n low after 3 beats of a frame, then sending frame {2, 1} -> result m_min=1 at idx 1, m_max=2 at idx 0, m_count=2; there is no output for the aborted frame.
REQ-039 SHALL be checked with back-to-back frames where m_ready=1 constantly -> each result is valid for exactly 1 cycle, and the next frame's first beat is accepted in the following cycle.
